// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core/LSU state encodings, register-input mux select,
// default datapath widths and the memory-op decode used by each thread's LSU.
package gpu_pkg;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int ADDR_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        REG_IN_ARITHMETIC = 2'b00,
        REG_IN_MEMORY     = 2'b01,
        REG_IN_CONSTANT   = 2'b10
    } reg_input_mux_t;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10
    } mem_op_t;

    // A load wins when the decoder flags both; the store is dropped for that instruction.
    function automatic mem_op_t decode_mem_op(input logic read_enable, input logic write_enable);
        if (read_enable)
            return MEM_OP_LOAD;
        else if (write_enable)
            return MEM_OP_STORE;
        else
            return MEM_OP_NONE;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port between a thread LSU (master) and the memory controller (slave):
// independent valid/ready read and write channels.
interface lsu_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one LDR/STR per memory instruction to data memory
// and holds the loaded byte on lsu_out for the core's UPDATE write-back.
module lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    lsu_if.master                mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    lsu_state_t state;
    mem_op_t    op;
    mem_op_t    next_op;

    assign next_op   = decode_mem_op(decoded_mem_read_enable, decoded_mem_write_enable);
    assign lsu_state = state;

    // NOTE: reset is sampled on the clock edge, so it lives inside the edge-triggered
    // block and is the first branch; it overrides enable and any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= LSU_IDLE;
            op                    <= MEM_OP_NONE;
            mem.mem_read_valid    <= 1'b0;
            mem.mem_read_address  <= '0;
            mem.mem_write_valid   <= 1'b0;
            mem.mem_write_address <= '0;
            mem.mem_write_data    <= '0;
            lsu_out               <= '0;
        end else if (enable) begin
            case (state)
                LSU_IDLE: begin
                    // The op is captured here so the WAITING handshake follows the
                    // instruction that started it, whatever the decoder shows later.
                    if (core_state == CORE_REQUEST && next_op != MEM_OP_NONE) begin
                        op    <= next_op;
                        state <= LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    if (op == MEM_OP_LOAD) begin
                        mem.mem_read_valid   <= 1'b1;
                        mem.mem_read_address <= rs[ADDR_BITS-1:0];
                    end else begin
                        mem.mem_write_valid   <= 1'b1;
                        mem.mem_write_address <= rs[ADDR_BITS-1:0];
                        mem.mem_write_data    <= rt;
                    end
                    state <= LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (op == MEM_OP_LOAD) begin
                        if (mem.mem_read_valid && mem.mem_read_ready) begin
                            lsu_out            <= mem.mem_read_data;
                            mem.mem_read_valid <= 1'b0;
                            state              <= LSU_DONE;
                        end
                    end else if (mem.mem_write_valid && mem.mem_write_ready) begin
                        mem.mem_write_valid <= 1'b0;
                        state               <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE)
                        state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu: stimulus pushes expected bus transactions and
// expected lsu_out values; a negedge monitor pops and compares them as the DUT produces them.
module tb_lsu;
    import gpu_pkg::*;

    typedef struct packed {
        logic       is_read;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    int tests = 0;
    int fails = 0;

    txn_t       acc_q[$];
    logic [7:0] done_q[$];

    lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();

    lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem                      (mem.master),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: acceptances and DONE entries are compared against the scoreboard queues.
    initial begin
        logic [1:0] prev_state = 2'b00;
        txn_t       t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mem.mem_read_valid || mem.mem_write_valid)
                check("one_port_valid", {31'd0, mem.mem_read_valid & mem.mem_write_valid}, 32'd0);
            if (!reset && enable && ((mem.mem_read_valid && mem.mem_read_ready) ||
                                     (mem.mem_write_valid && mem.mem_write_ready))) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    t = acc_q.pop_front();
                    check("acc_is_read", {31'd0, mem.mem_read_valid}, {31'd0, t.is_read});
                    if (t.is_read) begin
                        check("rd_addr", {24'd0, mem.mem_read_address}, {24'd0, t.addr});
                    end else begin
                        check("wr_addr", {24'd0, mem.mem_write_address}, {24'd0, t.addr});
                        check("wr_data", {24'd0, mem.mem_write_data}, {24'd0, t.data});
                    end
                end
            end
            if (lsu_state == 2'b11 && prev_state != 2'b11) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = done_q.pop_front();
                    check("done_lsu_out", {24'd0, lsu_out}, {24'd0, e});
                end
            end
            prev_state = lsu_state;
        end
    end

    // REQUEST edge then WAIT edge: afterwards the request is on the bus.
    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_state = CORE_REQUEST;
        rd_en = rd;
        wr_en = wr;
        rs = a;
        rt = d;
        cycle();
        check("state_requesting", {30'd0, lsu_state}, 32'd1);
        core_state = CORE_WAIT;
        cycle();
        check("state_waiting", {30'd0, lsu_state}, 32'd2);
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (lsu_state == 2'b11) begin
                seen = 1;
                break;
            end
        end
        mem.mem_read_ready  = 1'b0;
        mem.mem_write_ready = 1'b0;
        check("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    task automatic update_to_idle(input logic [7:0] exp_out);
        rd_en = 1'b0;
        wr_en = 1'b0;
        core_state = CORE_UPDATE;
        cycle();
        check("update_idle", {30'd0, lsu_state}, 32'd0);
        check("update_lsu_out", {24'd0, lsu_out}, {24'd0, exp_out});
        core_state = CORE_IDLE;
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        core_state = CORE_IDLE;
        rd_en = 1'b0;
        wr_en = 1'b0;
        rs = '0;
        rt = '0;
        mem.mem_read_ready  = 1'b0;
        mem.mem_read_data   = '0;
        mem.mem_write_ready = 1'b0;
        cycle();
        cycle();
        check("rst_state", {30'd0, lsu_state}, 32'd0);
        check("rst_rd_valid", {31'd0, mem.mem_read_valid}, 32'd0);
        check("rst_wr_valid", {31'd0, mem.mem_write_valid}, 32'd0);
        check("rst_addrs", {16'd0, mem.mem_read_address, mem.mem_write_address}, 32'd0);
        check("rst_wr_data", {24'd0, mem.mem_write_data}, 32'd0);
        check("rst_lsu_out", {24'd0, lsu_out}, 32'd0);
        reset = 1'b0;
        cycle();

        // LDR 0x2A, ready after three waiting cycles with 0x5C
        issue(1'b1, 1'b0, 8'h2A, 8'h00);
        check("ldr_valid", {31'd0, mem.mem_read_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("ldr_hold_addr", {24'd0, mem.mem_read_address}, 32'h2A);
            check("ldr_hold_valid", {31'd0, mem.mem_read_valid}, 32'd1);
        end
        acc_q.push_back('{is_read: 1'b1, addr: 8'h2A, data: 8'h5C});
        done_q.push_back(8'h5C);
        mem.mem_read_data  = 8'h5C;
        mem.mem_read_ready = 1'b1;
        wait_done(4);
        check("ldr_valid_drop", {31'd0, mem.mem_read_valid}, 32'd0);
        cycle();
        check("ldr_done_held", {30'd0, lsu_state}, 32'd3);
        check("ldr_out_held", {24'd0, lsu_out}, 32'h5C);
        update_to_idle(8'h5C);

        // STR 0x10 <- 0xA5, ready in the first valid cycle; lsu_out keeps 0x5C
        acc_q.push_back('{is_read: 1'b0, addr: 8'h10, data: 8'hA5});
        done_q.push_back(8'h5C);
        issue(1'b0, 1'b1, 8'h10, 8'hA5);
        check("str_valid", {31'd0, mem.mem_write_valid}, 32'd1);
        mem.mem_write_ready = 1'b1;
        wait_done(2);
        check("str_one_cycle_valid", {31'd0, mem.mem_write_valid}, 32'd0);
        update_to_idle(8'h5C);

        // Both enables set: read wins, write never asserted
        acc_q.push_back('{is_read: 1'b1, addr: 8'h03, data: 8'h99});
        done_q.push_back(8'h99);
        issue(1'b1, 1'b1, 8'h03, 8'h77);
        check("both_rd_valid", {31'd0, mem.mem_read_valid}, 32'd1);
        check("both_wr_quiet", {31'd0, mem.mem_write_valid}, 32'd0);
        mem.mem_write_ready = 1'b1;
        cycle();
        check("both_wr_ready_ignored", {30'd0, lsu_state}, 32'd2);
        check("both_wr_still_quiet", {31'd0, mem.mem_write_valid}, 32'd0);
        mem.mem_write_ready = 1'b0;
        mem.mem_read_data  = 8'h99;
        mem.mem_read_ready = 1'b1;
        wait_done(2);
        update_to_idle(8'h99);

        // Freeze while waiting: ready during enable=0 is ignored
        issue(1'b1, 1'b0, 8'h44, 8'h00);
        enable = 1'b0;
        mem.mem_read_data  = 8'h11;
        mem.mem_read_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("frz_state", {30'd0, lsu_state}, 32'd2);
            check("frz_valid", {31'd0, mem.mem_read_valid}, 32'd1);
            check("frz_addr", {24'd0, mem.mem_read_address}, 32'h44);
        end
        check("frz_out", {24'd0, lsu_out}, 32'h99);
        acc_q.push_back('{is_read: 1'b1, addr: 8'h44, data: 8'h3C});
        done_q.push_back(8'h3C);
        mem.mem_read_data = 8'h3C;
        enable = 1'b1;
        wait_done(2);
        update_to_idle(8'h3C);

        // Reset while waiting with read_valid high
        issue(1'b1, 1'b0, 8'h55, 8'h00);
        check("pre_rst_valid", {31'd0, mem.mem_read_valid}, 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_valid", {31'd0, mem.mem_read_valid | mem.mem_write_valid}, 32'd0);
        check("midrst_state", {30'd0, lsu_state}, 32'd0);
        check("midrst_out", {24'd0, lsu_out}, 32'd0);
        rd_en = 1'b0;
        core_state = CORE_IDLE;
        cycle();
        check("midrst_no_retry", {30'd0, lsu_state}, 32'd0);

        // No-op instruction through REQUEST/WAIT/UPDATE
        rd_en = 1'b0;
        wr_en = 1'b0;
        rs = 8'hFF;
        core_state = CORE_REQUEST;
        cycle();
        check("nop_req_idle", {30'd0, lsu_state}, 32'd0);
        core_state = CORE_WAIT;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("nop_wait_idle", {30'd0, lsu_state}, 32'd0);
            check("nop_no_valid", {31'd0, mem.mem_read_valid | mem.mem_write_valid}, 32'd0);
        end
        core_state = CORE_UPDATE;
        cycle();
        check("nop_upd_idle", {30'd0, lsu_state}, 32'd0);
        core_state = CORE_IDLE;
        cycle();
        cycle();

        check("acc_q_drained", acc_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
